vending_ctrl: RTL

Parametrised multi-item vending-machine controller for the Basys-class board. Accepts coin pulses into a half-unit credit register, debounces buy/refund buttons, vends the selected item when stock and credit allow, returns change on request and multiplexes credit and selection onto the 4-digit seven-segment display. Supersedes the fixed 3-item, timer-credited vending block; sits between board I/O and the display/LED pins.

---
 rtl/vend_pkg.sv | 47 ++++
 rtl/vending_ctrl_if.sv | 36 +++
 rtl/btn_debounce.sv | 41 ++++
 rtl/vending_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM states, coin
// decoding and active-low seven-segment encoding.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_DENY,
    S_REFUND
  } state_t;

  localparam logic [6:0] DIGIT_BLANK = 7'b111_1111;

  // Coin code to value in half-units.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd10;
    endcase
  endfunction

  // Hex digit to active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: return 7'b100_0000;
      4'h1: return 7'b111_1001;
      4'h2: return 7'b010_0100;
      4'h3: return 7'b011_0000;
      4'h4: return 7'b001_1001;
      4'h5: return 7'b001_0010;
      4'h6: return 7'b000_0010;
      4'h7: return 7'b111_1000;
      4'h8: return 7'b000_0000;
      4'h9: return 7'b001_0000;
      4'hA: return 7'b000_1000;
      4'hB: return 7'b000_0011;
      4'hC: return 7'b100_0110;
      4'hD: return 7'b010_0001;
      4'hE: return 7'b000_0110;
      default: return 7'b000_1110;
    endcase
  endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Board-side signal bundle of the vending controller: buttons, coin port,
// vend/change results, stock LEDs and the seven-segment display.
interface vending_ctrl_if #(
  parameter int N_ITEMS  = 4,
  parameter int CREDIT_W = 7
);
  localparam int ID_W = $clog2(N_ITEMS);

  logic                btnC;
  logic                btnR;
  logic                coin_valid;
  logic [1:0]          coin_val;
  logic [ID_W-1:0]     id;
  logic                vend_valid;
  logic [ID_W-1:0]     vend_id;
  logic                deny;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic [N_ITEMS-1:0]  led;
  logic [6:0]          seg;
  logic                dp;
  logic [3:0]          an;

  modport master (
    output btnC, btnR, coin_valid, coin_val, id,
    input  vend_valid, vend_id, deny, change_valid, change_amt, coin_reject,
           led, seg, dp, an
  );

  modport slave (
    input  btnC, btnR, coin_valid, coin_val, id,
    output vend_valid, vend_id, deny, change_valid, change_amt, coin_reject,
           led, seg, dp, an
  );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: two-flop synchroniser, stability counter, and a single
// one-cycle event on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_BITS = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic evt
);
  localparam logic [DEB_BITS-1:0] STABLE = {1'b1, {(DEB_BITS-1){1'b0}}};
  localparam logic [DEB_BITS-1:0] SAT    = STABLE + 1'b1;

  logic                sync1, sync2, level_q;
  logic [DEB_BITS-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      evt     <= 1'b0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_q <= sync2;
      evt     <= 1'b0;
      if (sync2 != level_q) begin
        cnt <= '0;
      end else if (cnt == STABLE) begin
        // Step past STABLE so the event fires once per stable period.
        cnt <= SAT;
        evt <= level_q;
      end else if (cnt != SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vending_ctrl.sv
// Multi-item vending controller: credit register, buy/refund FSM, stock
// counters and a four-digit multiplexed credit/selection display.
module vending_ctrl
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 5,
  parameter int CREDIT_W   = 7,
  parameter int CREDIT_MAX = 40,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {7'd8, 7'd6, 7'd5, 7'd3},
  parameter logic [N_ITEMS*STOCK_W-1:0]  INIT_STOCK = {5'd1, 5'd20, 5'd15, 5'd5},
  parameter int DEB_BITS   = 11,
  parameter int SCAN_DIV   = 250000
) (
  input logic           clk,
  input logic           rst,
  vending_ctrl_if.slave bus
);
  localparam int ID_W   = $clog2(N_ITEMS);
  localparam int SUM_W  = CREDIT_W + 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic buy_evt, refund_evt;

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_buy_deb (
    .clk(clk), .rst(rst), .btn_in(bus.btnC), .evt(buy_evt)
  );
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_refund_deb (
    .clk(clk), .rst(rst), .btn_in(bus.btnR), .evt(refund_evt)
  );

  state_t              state;
  logic [ID_W-1:0]     id_lat;
  logic [CREDIT_W-1:0] credit, credit_eff, credit_nxt, price_sel;
  logic [STOCK_W-1:0]  stock [N_ITEMS];
  logic [SUM_W-1:0]    coin_sum;
  logic                id_ok, can_vend, coin_ok;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    id_ok     = (int'(id_lat) < N_ITEMS);
    price_sel = '0;
    can_vend  = 1'b0;
    if (id_ok) begin
      price_sel = PRICES[id_lat*CREDIT_W +: CREDIT_W];
      can_vend  = (stock[id_lat] != '0) && (credit >= price_sel);
    end
    // A coin landing in VEND/REFUND is added to the post-transaction credit.
    credit_eff = credit;
    case (state)
      S_VEND:   credit_eff = credit - price_sel;
      S_REFUND: credit_eff = '0;
      default:  ;
    endcase
    coin_sum   = {1'b0, credit_eff} + SUM_W'(coin_value(bus.coin_val));
    coin_ok    = (coin_sum <= SUM_W'(CREDIT_MAX));
    credit_nxt = (bus.coin_valid && coin_ok) ? coin_sum[CREDIT_W-1:0] : credit_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      id_lat           <= '0;
      credit           <= '0;
      bus.vend_valid   <= 1'b0;
      bus.vend_id      <= '0;
      bus.deny         <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.change_amt   <= '0;
      bus.coin_reject  <= 1'b0;
      // NOTE: the stock array is a handful of counters that must restart at
      // INIT_STOCK, so it is reset like any other register, not left as RAM.
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= INIT_STOCK[i*STOCK_W +: STOCK_W];
    end else begin
      credit           <= credit_nxt;
      bus.coin_reject  <= bus.coin_valid && !coin_ok;
      bus.vend_valid   <= 1'b0;
      bus.deny         <= 1'b0;
      bus.change_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (refund_evt) begin
            state            <= S_REFUND;
            bus.change_valid <= 1'b1;
            bus.change_amt   <= credit_nxt;
          end else if (buy_evt) begin
            state  <= S_CHECK;
            id_lat <= bus.id;
          end
        end
        S_CHECK: begin
          if (can_vend) begin
            state          <= S_VEND;
            bus.vend_valid <= 1'b1;
            bus.vend_id    <= id_lat;
          end else begin
            state    <= S_DENY;
            bus.deny <= 1'b1;
          end
        end
        S_VEND: begin
          if (stock[id_lat] != '0) stock[id_lat] <= stock[id_lat] - 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) bus.led[i] = (stock[i] == '0);
  end

  // Display: digit 0 tenths, 1 units (dp lit), 2 tens (blank when 0), 3 id.
  logic [SCAN_W-1:0]   scan_cnt;
  logic [1:0]          digit;
  logic [CREDIT_W-2:0] whole;
  logic [3:0]          units, tens;
  logic [6:0]          seg_nxt;
  logic [3:0]          an_nxt;
  logic                dp_nxt;

  always_comb begin
    whole = credit[CREDIT_W-1:1];
    units = 4'(whole % 10);
    tens  = 4'(whole / 10);
    case (digit)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = seg_decode(credit[0] ? 4'd5 : 4'd0);
        dp_nxt  = 1'b1;
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = seg_decode(units);
        dp_nxt  = 1'b0;
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = (tens == 4'd0) ? DIGIT_BLANK : seg_decode(tens);
        dp_nxt  = 1'b1;
      end
      default: begin
        an_nxt  = 4'b0111;
        seg_nxt = seg_decode(4'(bus.id));
        dp_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      bus.an   <= 4'b1110;
      bus.seg  <= 7'b100_0000;
      bus.dp   <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= digit + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      bus.an  <= an_nxt;
      bus.seg <= seg_nxt;
      bus.dp  <= dp_nxt;
    end
  end
endmodule
